lock_sequencer: RTL and testbench
=================================

# lock_sequencer

Automatic airlock sequencer for the bathysphere dock. It sequences the outer door, the inner door and the chamber pressurizer through a complete arrival or departure cycle. It also arbitrates between arrival and departure requests, and enforces the door/pressure interlocks in one FSM. It sits between the operator/bathysphere request inputs and the door and pressurizer command lines.

## Interface
- PRESS_CYCLES, 7, cycles for one full pressurize or depressurize (≥1)
- DOOR_CYCLES, 2, cycles for one door open or close travel (≥1)
- clk  in  1  system clock (CLOCK_50 at top level)
- reset  in  1  asynchronous, active-high reset
- arrive_req  in  1  level request: bring bathysphere from ocean into habitat
- depart_req  in  1  level request: move bathysphere from habitat to ocean
- sub_present  in  1  chamber occupancy sensor
- arrive_grant  out  1  one-cycle pulse: arrival cycle accepted
- depart_grant  out  1  one-cycle pulse: departure cycle accepted
- outer_open  out  1  outer (ocean-side) door open command
- inner_open  out  1  inner (habitat-side) door open command
- pressurizing  out  1  pressurizer raising chamber to habitat pressure
- depressurizing  out  1  pressurizer lowering chamber to ocean pressure
- pressurized  out  1  chamber currently at habitat pressure
- busy  out  1  FSM not in IDLE

## Operation
- Direction register `dir`: ARRIVE uses door A = outer and door B = inner. DEPART uses door A = inner and door B = outer.
- Required chamber pressure before door A opens:
  - ARRIVE: pressurized=0.
  - DEPART: pressurized=1.
- States:
  - IDLE: requests are sampled here only. Accept a request, latch `dir`, then:
    - if the chamber is already at the required pressure → OPEN_A;
    - otherwise → EQ_PRE.
  - EQ_PRE: equalize to the door-A side for PRESS_CYCLES → OPEN_A.
  - OPEN_A: DOOR_CYCLES → WAIT_IN.
  - WAIT_IN: wait for sub_present=1 → CLOSE_A.
  - CLOSE_A: DOOR_CYCLES → EQ_MID.
  - EQ_MID: equalize to the door-B side for PRESS_CYCLES → OPEN_B.
  - OPEN_B: DOOR_CYCLES → WAIT_OUT.
  - WAIT_OUT: wait for sub_present=0 → CLOSE_B.
  - CLOSE_B: DOOR_CYCLES → IDLE.
- Equalize direction: pressurizing is asserted when the target is habitat pressure, depressurizing when the target is ocean pressure.
- `pressurized` is registered. It is set or cleared on the final cycle of an equalize state and is stable otherwise.
- Door A's open output is high in OPEN_A and WAIT_IN. Door B's open output is high in OPEN_B and WAIT_OUT. Both are low in every CLOSE, EQ and IDLE state.
- Interlock invariants, which must never be violated:
  - never outer_open & inner_open;
  - never any door open & (pressurizing | depressurizing);
  - never pressurizing & depressurizing.
- Arbitration: if only one request is asserted, it is granted. If both are asserted in IDLE, grant the direction not served last (round-robin). After reset, priority is ARRIVE.
- Requests asserted while busy are ignored, not queued. A request still held at return to IDLE is sampled on the next cycle.
- After a completed arrival pressurized=1; after a completed departure pressurized=0.

## Timing
- Reset values: all outputs 0, state IDLE, pressurized=0, priority ARRIVE. Reset applies asynchronously and overrides mid-sequence.
- Timed states use one down-counter:
  - loaded with N−1 on entry;
  - the state lasts exactly N cycles;
  - it exits when the count is 0.
- Counter width: $clog2(max(PRESS_CYCLES, DOOR_CYCLES)) + 1.
- Request sampled at edge k → state and grant change at edge k. The grant is high for exactly the first cycle out of IDLE and busy rises in that same cycle.
- WAIT states last at least 1 cycle. If the sensor condition already holds on entry, the exit happens at the next edge.
- Minimum cycle length without EQ_PRE: 4·DOOR_CYCLES + PRESS_CYCLES + 2 cycles. EQ_PRE adds PRESS_CYCLES.
- All outputs are registered or decoded from registered state; there is no combinational input-to-output path.

## Structure
- Package `lock_pkg`:
  - state enum (IDLE, EQ_PRE, OPEN_A, WAIT_IN, CLOSE_A, EQ_MID, OPEN_B, WAIT_OUT, CLOSE_B);
  - direction constants DIR_ARRIVE=0 and DIR_DEPART=1.
- Sub-module `lock_timer`: a loadable down-counter with a `done` flag, parameterized by width.
- Top-level instantiation replaces the manual KEY-driven door and pressurizer controls.

## Test plan
Parameters for all scenarios: PRESS_CYCLES=7, DOOR_CYCLES=2.
- Arrival from reset:
  - Stimulus: arrive_req=1, sub_present pulsed to 1 in WAIT_IN and to 0 in WAIT_OUT.
  - Required: arrive_grant is a 1-cycle pulse; outer_open high 2+ cycles; pressurizing high exactly 7 cycles; inner_open high; final pressurized=1 and busy=0.
- Departure with pressurized=1:
  - Required: no EQ_PRE; inner_open first; depressurizing high exactly 7 cycles; outer_open second; final pressurized=0.
- Arrival with pressurized=1:
  - Required: depressurizing 7 cycles before outer_open; then a normal arrival completes.
- Simultaneous requests:
  - Stimulus: arrive_req=depart_req=1 held continuously after reset.
  - Required: arrive_grant first, then depart_grant on the next IDLE, then arrive again.
- Reset mid-sequence:
  - Stimulus: assert reset in cycle 3 of EQ_MID.
  - Required: all outputs go to 0 asynchronously, state is IDLE, pressurized=0.
- Busy and interlocks:
  - Stimulus: toggle depart_req during an arrival.
  - Required: no grant is issued and the sequence is unaffected.
  - Assertion checks all interlock invariants every cycle across all scenarios.

Source files
------------

// File: rtl/lock_sequencer_pkg.sv
// Shared types and constants for the bathysphere airlock sequencer.
`timescale 1ns/1ps
package lock_pkg;

    typedef enum logic [3:0] {
        IDLE,
        EQ_PRE,
        OPEN_A,
        WAIT_IN,
        CLOSE_A,
        EQ_MID,
        OPEN_B,
        WAIT_OUT,
        CLOSE_B
    } state_t;

    localparam logic DIR_ARRIVE = 1'b0;
    localparam logic DIR_DEPART = 1'b1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Request/command bundle between the operator side and the airlock sequencer.
`timescale 1ns/1ps
interface lock_sequencer_if;

    logic arrive_req;
    logic depart_req;
    logic sub_present;
    logic arrive_grant;
    logic depart_grant;
    logic outer_open;
    logic inner_open;
    logic pressurizing;
    logic depressurizing;
    logic pressurized;
    logic busy;

    modport master (
        output arrive_req, depart_req, sub_present,
        input  arrive_grant, depart_grant, outer_open, inner_open,
        input  pressurizing, depressurizing, pressurized, busy
    );

    modport slave (
        input  arrive_req, depart_req, sub_present,
        output arrive_grant, depart_grant, outer_open, inner_open,
        output pressurizing, depressurizing, pressurized, busy
    );

endinterface

// File: rtl/lock_sequencer_timer.sv
// Loadable down-counter shared by all timed states; done while the count sits at zero.
`timescale 1ns/1ps
module lock_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Airlock FSM: arbitrates arrival/departure, sequences doors and pressurizer under interlock.
`timescale 1ns/1ps
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int PRESS_CYCLES = 7,
    parameter int DOOR_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             reset,
    lock_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(max2(PRESS_CYCLES, DOOR_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] PRESS_LOAD = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD  = CNT_W'(DOOR_CYCLES - 1);

    state_t           state, state_nx;
    logic             dir, dir_nx;
    logic             prio, prio_nx;
    logic             pz, pz_nx;
    logic             arrive_grant_q, depart_grant_q;
    logic             arr_g_nx, dep_g_nx;
    logic             pick;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             done;
    logic             door_a, door_b;

    lock_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            dir            <= DIR_ARRIVE;
            prio           <= DIR_ARRIVE;
            pz             <= 1'b0;
            arrive_grant_q <= 1'b0;
            depart_grant_q <= 1'b0;
        end else begin
            state          <= state_nx;
            dir            <= dir_nx;
            prio           <= prio_nx;
            pz             <= pz_nx;
            arrive_grant_q <= arr_g_nx;
            depart_grant_q <= dep_g_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        prio_nx  = prio;
        pz_nx    = pz;
        arr_g_nx = 1'b0;
        dep_g_nx = 1'b0;
        pick     = DIR_ARRIVE;
        load     = 1'b0;
        load_val = DOOR_LOAD;
        unique case (state)
            IDLE: begin
                if (bus.arrive_req || bus.depart_req) begin
                    // Contention goes to whichever direction was not served last.
                    pick     = (bus.arrive_req && bus.depart_req) ? prio : bus.depart_req;
                    dir_nx   = pick;
                    prio_nx  = ~pick;
                    arr_g_nx = (pick == DIR_ARRIVE);
                    dep_g_nx = (pick == DIR_DEPART);
                    load     = 1'b1;
                    if (pz == (pick == DIR_DEPART)) begin
                        state_nx = OPEN_A;
                        load_val = DOOR_LOAD;
                    end else begin
                        state_nx = EQ_PRE;
                        load_val = PRESS_LOAD;
                    end
                end
            end
            EQ_PRE: begin
                if (done) begin
                    state_nx = OPEN_A;
                    load     = 1'b1;
                    load_val = DOOR_LOAD;
                    pz_nx    = (dir == DIR_DEPART);
                end
            end
            OPEN_A: begin
                if (done) state_nx = WAIT_IN;
            end
            WAIT_IN: begin
                if (bus.sub_present) begin
                    state_nx = CLOSE_A;
                    load     = 1'b1;
                    load_val = DOOR_LOAD;
                end
            end
            CLOSE_A: begin
                if (done) begin
                    state_nx = EQ_MID;
                    load     = 1'b1;
                    load_val = PRESS_LOAD;
                end
            end
            EQ_MID: begin
                if (done) begin
                    state_nx = OPEN_B;
                    load     = 1'b1;
                    load_val = DOOR_LOAD;
                    pz_nx    = (dir == DIR_ARRIVE);
                end
            end
            OPEN_B: begin
                if (done) state_nx = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (!bus.sub_present) begin
                    state_nx = CLOSE_B;
                    load     = 1'b1;
                    load_val = DOOR_LOAD;
                end
            end
            CLOSE_B: begin
                if (done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Door A faces the side the bathysphere enters from; door B the side it leaves to.
    assign door_a = (state == OPEN_A) || (state == WAIT_IN);
    assign door_b = (state == OPEN_B) || (state == WAIT_OUT);

    assign bus.outer_open     = (dir == DIR_ARRIVE) ? door_a : door_b;
    assign bus.inner_open     = (dir == DIR_ARRIVE) ? door_b : door_a;
    assign bus.pressurizing   = ((state == EQ_PRE) && (dir == DIR_DEPART)) ||
                                ((state == EQ_MID) && (dir == DIR_ARRIVE));
    assign bus.depressurizing = ((state == EQ_PRE) && (dir == DIR_ARRIVE)) ||
                                ((state == EQ_MID) && (dir == DIR_DEPART));
    assign bus.pressurized    = pz;
    assign bus.busy           = (state != IDLE);
    assign bus.arrive_grant   = arrive_grant_q;
    assign bus.depart_grant   = depart_grant_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Scoreboard bench for lock_sequencer: per-cycle interlock checks plus per-transaction summaries.
`timescale 1ns/1ps
module tb_lock_sequencer;
    import lock_pkg::*;

    localparam int P = 7;
    localparam int D = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;

    lock_sequencer_if bus();

    lock_sequencer #(.PRESS_CYCLES(P), .DOOR_CYCLES(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int depart;
        int pre_press;
        int pre_depress;
        int mid_press;
        int mid_depress;
        int first_inner;
        int outer_cyc;
        int inner_cyc;
        int grants;
        int final_pz;
        int busy_cyc;
    } txn_t;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic txn_t mk(int dep, int pre_p, int pre_d, int mid_p, int mid_d,
                                int first_in, int fpz, int busy_c);
        txn_t t;
        t.depart      = dep;
        t.pre_press   = pre_p;
        t.pre_depress = pre_d;
        t.mid_press   = mid_p;
        t.mid_depress = mid_d;
        t.first_inner = first_in;
        t.outer_cyc   = D + 1;
        t.inner_cyc   = D + 1;
        t.grants      = 1;
        t.final_pz    = fpz;
        t.busy_cyc    = busy_c;
        return t;
    endfunction

    // Hand-derived transactions for P=7, D=2: 17 cycles without pre-equalize, 24 with.
    txn_t A0, A1, D0, D1;
    initial begin
        A0 = mk(0, 0, 0, 7, 0, 0, 1, 17);
        A1 = mk(0, 0, 7, 7, 0, 0, 1, 24);
        D1 = mk(1, 0, 0, 0, 7, 1, 0, 17);
        D0 = mk(1, 7, 0, 0, 7, 1, 0, 24);
    end

    // Bathysphere model: each door opening moves it through that door.
    initial begin
        logic pv_o, pv_i;
        pv_o = 1'b0;
        pv_i = 1'b0;
        bus.sub_present = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.sub_present = 1'b0;
                pv_o = 1'b0;
                pv_i = 1'b0;
            end else begin
                if ((bus.outer_open && !pv_o) || (bus.inner_open && !pv_i))
                    bus.sub_present = ~bus.sub_present;
                pv_o = bus.outer_open;
                pv_i = bus.inner_open;
            end
        end
    end

    txn_t cur;
    bit   in_txn = 1'b0;
    bit   door_seen = 1'b0;

    // Monitor
    initial begin
        int bad;
        txn_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_txn = 1'b0;
            end else begin
                bad = int'(bus.outer_open & bus.inner_open)
                    + int'((bus.outer_open | bus.inner_open) & (bus.pressurizing | bus.depressurizing))
                    + int'(bus.pressurizing & bus.depressurizing);
                chk("interlock", bad, 0);

                if (in_txn && !bus.busy) begin
                    in_txn = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_txn", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dir",         cur.depart,      e.depart);
                        chk("pre_press",   cur.pre_press,   e.pre_press);
                        chk("pre_depress", cur.pre_depress, e.pre_depress);
                        chk("mid_press",   cur.mid_press,   e.mid_press);
                        chk("mid_depress", cur.mid_depress, e.mid_depress);
                        chk("first_inner", cur.first_inner, e.first_inner);
                        chk("outer_cyc",   cur.outer_cyc,   e.outer_cyc);
                        chk("inner_cyc",   cur.inner_cyc,   e.inner_cyc);
                        chk("grants",      cur.grants,      e.grants);
                        chk("final_pz",    int'(bus.pressurized), e.final_pz);
                        chk("busy_cyc",    cur.busy_cyc,    e.busy_cyc);
                    end
                end

                if (!in_txn && (bus.arrive_grant || bus.depart_grant)) begin
                    in_txn = 1'b1;
                    door_seen = 1'b0;
                    cur = mk(int'(bus.depart_grant), 0, 0, 0, 0, 0, 0, 0);
                    cur.outer_cyc = 0;
                    cur.inner_cyc = 0;
                    cur.grants = 0;
                end

                if (in_txn) begin
                    cur.busy_cyc  += int'(bus.busy);
                    cur.grants    += int'(bus.arrive_grant) + int'(bus.depart_grant);
                    cur.outer_cyc += int'(bus.outer_open);
                    cur.inner_cyc += int'(bus.inner_open);
                    if (!door_seen && (bus.outer_open || bus.inner_open)) begin
                        door_seen = 1'b1;
                        cur.first_inner = int'(bus.inner_open);
                    end
                    if (door_seen) begin
                        cur.mid_press   += int'(bus.pressurizing);
                        cur.mid_depress += int'(bus.depressurizing);
                    end else begin
                        cur.pre_press   += int'(bus.pressurizing);
                        cur.pre_depress += int'(bus.depressurizing);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus.arrive_grant || bus.depart_grant;
        end
        chk("grant_timeout", int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.busy;
        end
        chk("idle_timeout", int'(ok), 1);
    endtask

    task automatic run_single(input bit a, input bit d, input txn_t e);
        exp_q.push_back(e);
        bus.arrive_req = a;
        bus.depart_req = d;
        wait_grant();
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
        wait_idle();
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_arrive_grant"},   int'(bus.arrive_grant),   0);
        chk({tag, "_depart_grant"},   int'(bus.depart_grant),   0);
        chk({tag, "_outer_open"},     int'(bus.outer_open),     0);
        chk({tag, "_inner_open"},     int'(bus.inner_open),     0);
        chk({tag, "_pressurizing"},   int'(bus.pressurizing),   0);
        chk({tag, "_depressurizing"}, int'(bus.depressurizing), 0);
        chk({tag, "_pressurized"},    int'(bus.pressurized),    0);
        chk({tag, "_busy"},           int'(bus.busy),           0);
    endtask

    initial begin
        bit ok;
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
        reset = 1'b1;
        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        run_single(1'b1, 1'b0, A0);
        run_single(1'b0, 1'b1, D1);
        run_single(1'b0, 1'b1, D0);
        run_single(1'b1, 1'b0, A0);

        // Arrival from pressurized chamber while departure requests chatter.
        exp_q.push_back(A1);
        bus.arrive_req = 1'b1;
        wait_grant();
        bus.arrive_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.busy;
            if (!ok && (i % 3 == 0)) bus.depart_req = ~bus.depart_req;
        end
        bus.depart_req = 1'b0;
        chk("chatter_idle_timeout", int'(ok), 1);
        tick(3);
        chk("no_queued_grant", int'(bus.busy), 0);

        // Both requests held after reset: arrive, depart, arrive.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_q.push_back(A0);
        exp_q.push_back(D1);
        exp_q.push_back(A0);
        bus.arrive_req = 1'b1;
        bus.depart_req = 1'b1;
        wait_grant();
        wait_grant();
        wait_grant();
        bus.arrive_req = 1'b0;
        bus.depart_req = 1'b0;
        wait_idle();
        tick(1);

        // Departure from pressurized chamber, reset in the third EQ_MID cycle.
        bus.depart_req = 1'b1;
        wait_grant();
        bus.depart_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus.depressurizing;
        end
        chk("eq_mid_reached", int'(ok), 1);
        chk("pz_before_reset", int'(bus.pressurized), 1);
        tick(2);
        #1 reset = 1'b1;
        #1 check_all_zero("async_reset");
        tick(2);
        reset = 1'b0;
        tick(1);

        run_single(1'b1, 1'b0, A0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required completion before 100000ns");
        $fatal(1, "watchdog");
    end

endmodule
